// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared state type and default widths for the matvec scheduler
package matvec_pkg;

  localparam int MAX_ROWS_DEF = 64;
  localparam int MAX_COLS_DEF = 64;
  localparam int ROW_W        = $clog2(MAX_ROWS_DEF) + 1;
  localparam int COL_W        = $clog2(MAX_COLS_DEF) + 1;
  localparam int ENG_AW       = $clog2(MAX_ROWS_DEF * MAX_COLS_DEF);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_GRANT = 5'b00010,
    S_START = 5'b00100,
    S_RUN   = 5'b01000,
    S_DONE  = 5'b10000
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter
  import matvec_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IW-1:0]      index_o
);

  // Scan from ptr_i upward with wrap; the first requester seen wins.
  always_comb begin
    int   j;
    logic found;
    onehot_o = '0;
    index_o  = '0;
    found    = 1'b0;
    j        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        index_o     = IW'(j);
        onehot_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matvec_scheduler.sv
// rtl/matvec_scheduler.sv - shares one matvec engine among several clients
module matvec_scheduler
  import matvec_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MAX_ROWS   = MAX_ROWS_DEF,
  parameter int MAX_COLS   = MAX_COLS_DEF,
  parameter int BANDWIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_AW     = 16,
  localparam int RW  = $clog2(MAX_ROWS) + 1,
  localparam int CW  = $clog2(MAX_COLS) + 1,
  localparam int EAW = $clog2(MAX_ROWS * MAX_COLS),
  localparam int VAW = $clog2(MAX_COLS),
  localparam int VW  = BANDWIDTH * 16,
  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*RW-1:0]   req_num_rows,
  input  logic [NUM_REQ*CW-1:0]   req_num_cols,
  input  logic [NUM_REQ*MEM_AW-1:0] req_mat_base,
  input  logic [NUM_REQ-1:0]      req_vec_we,
  input  logic [NUM_REQ*VAW-1:0]  req_vec_addr,
  input  logic [NUM_REQ*VW-1:0]   req_vec_data,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic                    err,
  output logic [NUM_REQ-1:0]      res_valid,
  output logic [2*DATA_WIDTH-1:0] res_data,
  output logic [RW-1:0]           res_row,
  output logic                    mv_start,
  output logic [RW-1:0]           mv_num_rows,
  output logic [CW-1:0]           mv_num_cols,
  output logic                    mv_vec_we,
  output logic [VAW-1:0]          mv_vec_addr,
  output logic [VW-1:0]           mv_vec_data,
  input  logic [EAW-1:0]          mv_matrix_addr,
  input  logic                    mv_matrix_enable,
  input  logic [2*DATA_WIDTH-1:0] mv_result_out,
  input  logic                    mv_result_valid,
  input  logic                    mv_busy,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic                    mem_enable
);

  sched_state_t        state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic [RW-1:0]       rows_q, rows_d, row_cnt_q, row_cnt_d;
  logic [CW-1:0]       cols_q, cols_d;
  logic [MEM_AW-1:0]   base_q, base_d;
  logic                busy_seen_q, busy_seen_d, err_q, err_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, pick_oh, owner_oh;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .index_o  (pick_idx)
  );

  // Job state registers; a reset mid-job simply abandons the job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      base_q      <= '0;
      row_cnt_q   <= '0;
      busy_seen_q <= 1'b0;
      err_q       <= 1'b0;
      gnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      base_q      <= base_d;
      row_cnt_q   <= row_cnt_d;
      busy_seen_q <= busy_seen_d;
      err_q       <= err_d;
      gnt_q       <= gnt_d;
    end
  end

  // Next-state logic; a result strobe arriving outside S_RUN is a protocol error.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    base_d      = base_q;
    row_cnt_d   = row_cnt_q;
    busy_seen_d = busy_seen_q;
    gnt_d       = gnt_q;
    err_d       = err_q | (mv_result_valid && (state_q != S_RUN));
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = pick_idx;
          rows_d  = req_num_rows[pick_idx*RW +: RW];
          cols_d  = req_num_cols[pick_idx*CW +: CW];
          base_d  = req_mat_base[pick_idx*MEM_AW +: MEM_AW];
          gnt_d   = pick_oh;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (rows_q == '0 || cols_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_START;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (mv_busy) busy_seen_d = 1'b1;
        if (mv_result_valid) row_cnt_d = row_cnt_q + RW'(1);
        if (busy_seen_q && !mv_busy) state_d = S_DONE;
      end
      S_DONE: begin
        if (row_cnt_q != rows_q) err_d = 1'b1;
        rr_ptr_d    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
        busy_seen_d = 1'b0;
        row_cnt_d   = '0;
        gnt_d       = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, result routing and vector forwarding from the current owner.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    mv_vec_we         = 1'b0;
    mv_vec_addr       = '0;
    mv_vec_data       = '0;
    if (|gnt_q) begin
      mv_vec_we   = req_vec_we[owner_q];
      mv_vec_addr = req_vec_addr[owner_q*VAW +: VAW];
      mv_vec_data = req_vec_data[owner_q*VW +: VW];
    end
    done       = (state_q == S_DONE) ? owner_oh : '0;
    res_valid  = (state_q == S_RUN && mv_result_valid) ? owner_oh : '0;
    mv_start   = (state_q == S_START);
    mem_enable = (state_q == S_RUN) && mv_matrix_enable;
  end

  assign gnt         = gnt_q;
  assign err         = err_q;
  assign res_data    = mv_result_out;
  assign res_row     = row_cnt_q;
  assign mv_num_rows = rows_q;
  assign mv_num_cols = cols_q;
  assign mem_addr    = base_q + MEM_AW'(mv_matrix_addr);

endmodule

// File: tb/tb_matvec_scheduler.sv
// tb/tb_matvec_scheduler.sv - self-checking bench for matvec_scheduler
module tb_matvec_scheduler;

  localparam int N   = 4;
  localparam int RW  = 7;
  localparam int CW  = 7;
  localparam int AW  = 16;
  localparam int VAW = 6;
  localparam int VW  = 256;
  localparam int EAW = 12;

  typedef struct {
    int          client;
    int          rows;
    int          cols;
    logic [15:0] base;
    logic [11:0] eaddr;
    logic [15:0] exp_mem;
  } job_t;

  typedef struct {
    logic [N-1:0]  valid;
    logic [31:0]   data;
    logic [RW-1:0] row;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]      req;
  logic [N*RW-1:0]   req_num_rows;
  logic [N*CW-1:0]   req_num_cols;
  logic [N*AW-1:0]   req_mat_base;
  logic [N-1:0]      req_vec_we;
  logic [N*VAW-1:0]  req_vec_addr;
  logic [N*VW-1:0]   req_vec_data;
  logic [N-1:0]      gnt, done, res_valid;
  logic              err, mv_start, mv_vec_we, mem_enable;
  logic [31:0]       res_data, mv_result_out;
  logic [RW-1:0]     res_row, mv_num_rows;
  logic [CW-1:0]     mv_num_cols;
  logic [VAW-1:0]    mv_vec_addr;
  logic [VW-1:0]     mv_vec_data;
  logic [EAW-1:0]    mv_matrix_addr;
  logic              mv_matrix_enable, mv_result_valid, mv_busy;
  logic [AW-1:0]     mem_addr;

  int n_pass  = 0;
  int n_total = 0;
  sb_t sb[$];
  sb_t mon_e;
  job_t tbl[4];

  matvec_scheduler dut (
    .clk(clk), .rst(rst), .req(req),
    .req_num_rows(req_num_rows), .req_num_cols(req_num_cols), .req_mat_base(req_mat_base),
    .req_vec_we(req_vec_we), .req_vec_addr(req_vec_addr), .req_vec_data(req_vec_data),
    .gnt(gnt), .done(done), .err(err), .res_valid(res_valid), .res_data(res_data),
    .res_row(res_row), .mv_start(mv_start), .mv_num_rows(mv_num_rows),
    .mv_num_cols(mv_num_cols), .mv_vec_we(mv_vec_we), .mv_vec_addr(mv_vec_addr),
    .mv_vec_data(mv_vec_data), .mv_matrix_addr(mv_matrix_addr),
    .mv_matrix_enable(mv_matrix_enable), .mv_result_out(mv_result_out),
    .mv_result_valid(mv_result_valid), .mv_busy(mv_busy),
    .mem_addr(mem_addr), .mem_enable(mem_enable)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int c);
    logic [N-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && res_valid != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_result", res_valid, '0);
      end else begin
        mon_e = sb.pop_front();
        check("res_valid", res_valid, mon_e.valid);
        check("res_data", res_data, mon_e.data);
        check("res_row", res_row, mon_e.row);
      end
    end
  end

  task automatic drive_idle_inputs;
    req              = '0;
    req_vec_we       = '0;
    mv_matrix_addr   = '0;
    mv_matrix_enable = 1'b0;
    mv_result_out    = '0;
    mv_result_valid  = 1'b0;
    mv_busy          = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive_idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic set_dims(input int c, input int rows, input int cols, input logic [15:0] base);
    req_num_rows[c*RW +: RW] = RW'(rows);
    req_num_cols[c*CW +: CW] = CW'(cols);
    req_mat_base[c*AW +: AW] = base;
  endtask

  // Called in the S_START cycle; acts as the engine and ends in the S_DONE cycle.
  task automatic engine_run(input int c, input int rows, input logic [11:0] eaddr,
                            input logic [15:0] exp_mem);
    logic [31:0] d;
    tick();
    check("start_one_cycle", mv_start, 1'b0);
    mv_busy          = 1'b1;
    mv_matrix_addr   = eaddr;
    mv_matrix_enable = 1'b1;
    #1;
    check("mem_addr", mem_addr, exp_mem);
    check("mem_enable_run", mem_enable, 1'b1);
    tick();
    mv_matrix_enable = 1'b0;
    for (int r = 0; r < rows; r++) begin
      d               = $urandom;
      mv_result_valid = 1'b1;
      mv_result_out   = d;
      sb.push_back('{oh(c), d, RW'(r)});
      tick();
    end
    mv_result_valid = 1'b0;
    mv_busy         = 1'b0;
    tick();
    check("done_pulse", done, oh(c));
    check("gnt_in_done", gnt, oh(c));
  endtask

  task automatic run_job(input job_t j);
    int           other;
    logic [255:0] vd;
    other = (j.client + 1) % N;
    set_dims(j.client, j.rows, j.cols, j.base);
    req[j.client] = 1'b1;
    tick();
    check("grant", gnt, oh(j.client));
    check("no_start_in_grant", mv_start, 1'b0);
    check("dims", {mv_num_rows, mv_num_cols}, {RW'(j.rows), CW'(j.cols)});
    req_vec_we[other] = 1'b1;
    req_vec_addr[other*VAW +: VAW] = 6'h2a;
    for (int k = 0; k < 8; k++) req_vec_data[other*VW + k*32 +: 32] = $urandom;
    #1;
    check("foreign_write_dropped", mv_vec_we, 1'b0);
    req_vec_we[other] = 1'b0;
    for (int k = 0; k < 8; k++) vd[k*32 +: 32] = $urandom;
    req_vec_we[j.client] = 1'b1;
    req_vec_addr[j.client*VAW +: VAW] = VAW'(j.client + 5);
    req_vec_data[j.client*VW +: VW] = vd;
    #1;
    check("vec_we_pass", mv_vec_we, 1'b1);
    check("vec_addr_pass", mv_vec_addr, VAW'(j.client + 5));
    check("vec_data_pass", mv_vec_data, vd);
    tick();
    req_vec_we[j.client] = 1'b0;
    check("mv_start", mv_start, 1'b1);
    engine_run(j.client, j.rows, j.eaddr, j.exp_mem);
    req[j.client] = 1'b0;
    tick();
    check("done_cleared", done, '0);
    check("gnt_cleared", gnt, '0);
    check("no_err", err, 1'b0);
  endtask

  initial begin
    job_t jj;
    tbl[0] = '{0, 4, 16, 16'h0100, 12'h005, 16'h0105};
    tbl[1] = '{1, 2,  8, 16'h1234, 12'h0ff, 16'h1333};
    tbl[2] = '{3, 3,  4, 16'hfff0, 12'h020, 16'h0010};
    tbl[3] = '{2, 1, 64, 16'h0000, 12'hfff, 16'h0fff};
    req_num_rows = '0;
    req_num_cols = '0;
    req_mat_base = '0;
    req_vec_addr = '0;
    req_vec_data = '0;
    rst = 1'b1;
    drive_idle_inputs();
    tick();
    check("rst_gnt", gnt, '0);
    check("rst_done", done, '0);
    check("rst_err", err, 1'b0);
    check("rst_start", mv_start, 1'b0);
    check("rst_vec_we", mv_vec_we, 1'b0);
    check("rst_res_valid", res_valid, '0);
    check("rst_mem_enable", mem_enable, 1'b0);
    check("rst_res_row", res_row, '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_job(tbl[i]);

    mv_result_valid = 1'b1;
    #1;
    check("stray_res_valid", res_valid, '0);
    tick();
    mv_result_valid = 1'b0;
    check("stray_sets_err", err, 1'b1);

    do_reset();
    set_dims(0, 0, 4, 16'h0300);
    req[0] = 1'b1;
    tick();
    check("zero_grant", gnt, 4'b0001);
    tick();
    check("zero_no_start", mv_start, 1'b0);
    check("zero_done", done, 4'b0001);
    check("zero_err", err, 1'b1);
    req[0] = 1'b0;
    tick();
    check("zero_done_once", done, '0);
    check("err_sticky", err, 1'b1);

    do_reset();
    for (int c = 0; c < N; c++) set_dims(c, 1, 1, 16'(c * 256));
    req = '1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("rr_order", gnt, oh(k % N));
      tick();
      check("rr_start", mv_start, 1'b1);
      engine_run(k % N, 1, 12'h000, 16'(((k % N)) * 256));
      if (k == 4) req = '0;
      tick();
      check("idle_gap", gnt, '0);
      if (k < 4) tick();
    end
    check("rr_no_err", err, 1'b0);

    set_dims(2, 4, 8, 16'h0200);
    req[2] = 1'b1;
    tick();
    check("mid_grant", gnt, 4'b0100);
    tick();
    tick();
    mv_busy          = 1'b1;
    mv_matrix_enable = 1'b1;
    mv_matrix_addr   = 12'h003;
    mv_result_valid  = 1'b1;
    mv_result_out    = 32'hdead_beef;
    sb.push_back('{4'b0100, 32'hdead_beef, RW'(0)});
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", gnt, '0);
    check("mid_rst_done", done, '0);
    check("mid_rst_start", mv_start, 1'b0);
    check("mid_rst_mem_enable", mem_enable, 1'b0);
    check("mid_rst_res_valid", res_valid, '0);
    check("mid_rst_res_row", res_row, '0);
    check("mid_rst_vec_we", mv_vec_we, 1'b0);
    drive_idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    check("no_done_after_rst", done, '0);
    tick();
    check("no_gnt_after_rst", gnt, '0);
    jj = '{2, 2, 8, 16'h0040, 12'h010, 16'h0050};
    run_job(jj);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/matvec_scheduler.md
# matvec_scheduler

- Shares one `matvec_multiplier` engine among `NUM_REQ` clients, such as LSTM gate controllers.
- Arbitration is round-robin and non-preemptive.
- Per job it:
  - latches the winning client's matrix dimensions and matrix base address, then starts the engine;
  - forwards that client's vector writes to the engine;
  - relocates the engine's matrix SRAM addresses by the base address;
  - routes row results back to the client and signals completion.
- Sits between the client controllers and the engine/matrix SRAM port.

## Interface
- `NUM_REQ`, 4: number of clients (2..8).
- `MAX_ROWS`, 64; `MAX_COLS`, 64; `BANDWIDTH`, 16; `DATA_WIDTH`, 16: must match the engine.
- `MEM_AW`, 16: matrix SRAM address width.
- Local widths: `ROW_W`=$clog2(MAX_ROWS)+1, `COL_W`=$clog2(MAX_COLS)+1, `ENG_AW`=$clog2(MAX_ROWS*MAX_COLS).

- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  level request; held until the matching `done` pulse.
- `req_num_rows`  in  NUM_REQ×ROW_W  per-client row count.
- `req_num_cols`  in  NUM_REQ×COL_W  per-client column count.
- `req_mat_base`  in  NUM_REQ×MEM_AW  per-client matrix base word address.
- `req_vec_we`  in  NUM_REQ  per-client vector write enable.
- `req_vec_addr`  in  NUM_REQ×$clog2(MAX_COLS)  per-client vector chunk address.
- `req_vec_data`  in  NUM_REQ×BANDWIDTH×16  per-client vector chunk, Q4.12.
- `gnt`  out  NUM_REQ  one-hot grant, registered.
- `done`  out  NUM_REQ  one-cycle completion pulse.
- `err`  out  1  sticky error flag; cleared only by reset.
- `res_valid`  out  NUM_REQ  per-client row-result strobe.
- `res_data`  out  2×DATA_WIDTH  shared result bus, Q20.12.
- `res_row`  out  ROW_W  index of the row in `res_data`.
- `mv_start`  out  1  engine start.
- `mv_num_rows`  out  ROW_W  engine dimension.
- `mv_num_cols`  out  COL_W  engine dimension.
- `mv_vec_we`, `mv_vec_addr`, `mv_vec_data`  out  engine vector port.
- `mv_matrix_addr`  in  ENG_AW  engine matrix address.
- `mv_matrix_enable`  in  1  engine matrix enable.
- `mv_result_out`  in  2×DATA_WIDTH  engine result.
- `mv_result_valid`  in  1  engine result strobe.
- `mv_busy`  in  1  engine busy.
- `mem_addr`  out  MEM_AW  `req_mat_base[owner] + mv_matrix_addr`; combinational, wraps modulo 2^MEM_AW.
- `mem_enable`  out  1  equals `mv_matrix_enable` while in S_RUN; 0 otherwise.

## Operation
- **States** (one-hot): S_IDLE, S_GRANT, S_START, S_RUN, S_DONE.
- **S_IDLE**
  - If `req` is nonzero, the round-robin pick is the first set bit at or after `rr_ptr`, wrapping.
  - Latch owner index, `num_rows`, `num_cols` and `mat_base`; go to S_GRANT.
- **S_GRANT**
  - `gnt[owner]`=1 from this state through S_DONE inclusive.
  - The owner may begin vector writes.
  - If the latched rows or cols are 0: set `err` and go to S_DONE without starting the engine.
  - Otherwise go to S_START.
- **S_START**
  - `mv_start`=1 for exactly this cycle; go to S_RUN.
- **S_RUN**
  - Set `busy_seen` when `mv_busy`=1.
  - Exit to S_DONE when `busy_seen` is set and `mv_busy`=0.
- **S_DONE**
  - `done[owner]`=1 for one cycle.
  - If `row_cnt`≠`num_rows`, set `err`.
  - `rr_ptr` ← owner+1 (mod NUM_REQ); clear `busy_seen` and `row_cnt`; go to S_IDLE.
- **Vector forwarding**
  - `mv_vec_*` = `req_vec_*[owner]` whenever `gnt` is nonzero; `mv_vec_we`=0 otherwise.
  - Writes from non-granted clients are dropped silently.
- **Dimensions**: `mv_num_rows` and `mv_num_cols` are driven from the latched values, stable from S_GRANT until S_IDLE.
- **Result routing**
  - On `mv_result_valid` in S_RUN: `res_valid[owner]`=1 and `res_data`=`mv_result_out`, combinationally.
  - `res_row`=`row_cnt`; `row_cnt` then increments.
  - Results outside S_RUN are dropped and set `err`.
- **Request deassertion**: `req[owner]` dropping mid-job does not abort the job; it still completes and pulses `done`.

## Timing
- **Reset values**:
  - state = S_IDLE, `rr_ptr`=0;
  - `gnt`, `done`, `err`, `mv_start`, `mv_vec_we`, `res_valid`, `mem_enable` = 0;
  - `res_row`=0.
- **Reset mid-job**: the job is lost; no `done` pulse. The engine shares `rst` and returns to idle too.
- **Request-to-grant latency**: `req` sampled in S_IDLE at edge N → `gnt` high after edge N+1 → `mv_start` high after edge N+2.
- **Back-to-back jobs**: minimum one S_IDLE cycle between a `done` pulse and the next `gnt`.
- **Simultaneous requests**: resolved strictly by `rr_ptr`; a pending request waits at most NUM_REQ−1 jobs.
- **Request and done in the same cycle**: a new `req` from the finishing owner in the same cycle as its `done` is eligible, but only after the other clients at or beyond `rr_ptr`.

## Structure
- Package `matvec_pkg`: `sched_state_t` enum, plus width localparams `ROW_W`, `COL_W` and `ENG_AW`.
- Sub-module `rr_arbiter`:
  - `NUM_REQ`-wide round-robin pick;
  - inputs `req` and `ptr`; outputs one-hot and index;
  - purely combinational, with the pointer register kept in the scheduler.

## Test plan
- **Single job**: `req`=0001, 4×16 job, base 0x0100 → `mv_start` two cycles after `req`; `mem_addr`=0x0100+`mv_matrix_addr`; four `res_valid[0]` with `res_row` 0..3; `done[0]` pulse; `err`=0.
- **Fairness**: `req`=1111 held, four jobs → grant order 0,1,2,3; fifth grant back to client 0.
- **Vector isolation**: client 2 writes while client 1 is granted → `mv_vec_we` stays 0; client 1's writes pass through unchanged.
- **Zero dimensions**: `num_rows`=0 → no `mv_start`; `done` pulse at S_DONE; `err`=1.
- **Reset mid-job**: `rst` during S_RUN → all outputs return to reset values; no `done`; the next request is granted normally.
- **Address wrap**: base 0xFFF0 with `mv_matrix_addr`=0x20 → `mem_addr`=0x0010.
